// File: rtl/arith_word_sequencer_if.sv
// Handshake and status bundle between instruction decode (master) and the
// arithmetic word-time sequencer (slave). Suffixes are from the sequencer's side.
interface arith_word_sequencer_if #(
    parameter int STEP_W = 4
);
    logic              start_i;
    logic [3:0]        opcode_i;
    logic              divz_i;
    logic              abort_i;
    logic [4:0]        bit_o;
    logic              firstbit_o;
    logic              lastbit_o;
    logic              pa_o;
    logic              pb_o;
    logic              pc_o;
    logic [STEP_W-1:0] step_o;
    logic              laststep_o;
    logic              busy_o;
    logic              done_o;
    logic              diverr_o;

    modport master (
        output start_i, opcode_i, divz_i, abort_i,
        input  bit_o, firstbit_o, lastbit_o, pa_o, pb_o, pc_o,
               step_o, laststep_o, busy_o, done_o, diverr_o
    );

    modport slave (
        input  start_i, opcode_i, divz_i, abort_i,
        output bit_o, firstbit_o, lastbit_o, pa_o, pb_o, pc_o,
               step_o, laststep_o, busy_o, done_o, diverr_o
    );
endinterface

// File: rtl/arith_word_sequencer.sv
// Word-time sequencer: free-running bit-time count plus the PA / N x PB / PC
// phase sequence that gates the serial adder, shift logic and writeback.
//
// state   | meaning
// IDLE    | no operation
// PEND    | start accepted, waiting for the next word boundary
// PHA     | PA word (operand fetch / setup)
// PHB     | PB words, STEP indexes the current one
// PHC     | PC word (writeback), DONE on its last bit
module arith_word_sequencer #(
    parameter int WORD_BITS = 28,
    parameter int MPY_WORDS = 4,
    parameter int DIV_WORDS = 8,
    parameter int STEP_W    = 4
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    arith_word_sequencer_if.slave bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PEND = 3'd1;
    localparam logic [2:0] ST_PHA  = 3'd2;
    localparam logic [2:0] ST_PHB  = 3'd3;
    localparam logic [2:0] ST_PHC  = 3'd4;

    localparam logic [4:0]        BIT_LAST = 5'(WORD_BITS - 1);
    localparam logic [3:0]        OP_MPY   = 4'h4;
    localparam logic [3:0]        OP_DIV   = 4'h5;
    localparam logic [STEP_W-1:0] MPY_LAST = STEP_W'(MPY_WORDS - 1);
    localparam logic [STEP_W-1:0] DIV_LAST = STEP_W'(DIV_WORDS - 1);

    logic [4:0]        bit_q, bit_d;
    logic [2:0]        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              err_q, err_d;
    logic              lastbit;
    logic [STEP_W-1:0] step_last;

    assign lastbit = (bit_q == BIT_LAST);
    assign bit_d   = lastbit ? 5'd0 : bit_q + 5'd1;

    always_comb begin
        step_last = '0;
        if (op_q == OP_MPY)
            step_last = MPY_LAST;
        else if (op_q == OP_DIV)
            step_last = DIV_LAST;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        step_d  = step_q;
        err_d   = err_q;
        if (bus.abort_i) begin
            // Abort also vetoes a start presented in the same cycle.
            state_d = ST_IDLE;
            step_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        op_d    = bus.opcode_i;
                        state_d = lastbit ? ST_PHA : ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (lastbit)
                        state_d = ST_PHA;
                end
                ST_PHA: begin
                    if (lastbit) begin
                        step_d = '0;
                        if (op_q == OP_DIV && bus.divz_i) begin
                            state_d = ST_PHC;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_PHB;
                        end
                    end
                end
                ST_PHB: begin
                    if (lastbit) begin
                        if (step_q == step_last) begin
                            state_d = ST_PHC;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                ST_PHC: begin
                    if (lastbit) begin
                        err_d = 1'b0;
                        if (bus.start_i) begin
                            op_d    = bus.opcode_i;
                            state_d = ST_PHA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_q   <= 5'd0;
            state_q <= ST_IDLE;
            op_q    <= 4'h0;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            bit_q   <= bit_d;
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign bus.bit_o      = bit_q;
    assign bus.firstbit_o = (bit_q == 5'd0);
    assign bus.lastbit_o  = lastbit;
    assign bus.pa_o       = (state_q == ST_PHA);
    assign bus.pb_o       = (state_q == ST_PHB);
    assign bus.pc_o       = (state_q == ST_PHC);
    assign bus.step_o     = step_q;
    assign bus.laststep_o = (state_q == ST_PHB) && (step_q == step_last);
    assign bus.busy_o     = (state_q != ST_IDLE);
    // An abort landing on the PC last bit must still cancel the completion,
    // so the pulse is the only output qualified by an input.
    assign bus.done_o     = (state_q == ST_PHC) && lastbit && !bus.abort_i;
    assign bus.diverr_o   = bus.done_o && err_q;
endmodule
